// File: rtl/frequency_analyzer.sv
// Counts synchronized rising edges of signal_in between start and stop strobes.
// Define PERIOD_MEASURE_EN to add last_period (cycles between the last two counted edges).
module frequency_analyzer #(
    parameter int COUNTER_WIDTH = 32,
    parameter int SYNC_STAGES   = 2,
    parameter int PERIOD_WIDTH  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     signal_in,
    output logic [COUNTER_WIDTH-1:0] frequency,
    output logic                     overflow,
    output logic                     result_valid,
    output logic                     busy
`ifdef PERIOD_MEASURE_EN
    ,
    output logic [PERIOD_WIDTH-1:0]  last_period
`endif
);

    typedef enum logic {IDLE, COUNTING} state_t;

    state_t                   state, state_next;
    logic [SYNC_STAGES-1:0]   sync_q;
    logic                     sync_prev, start_prev, stop_prev;
    logic                     sig_edge, start_rise, stop_rise;
    logic [COUNTER_WIDTH-1:0] counter, counter_next, cnt_inc, frequency_next;
    logic                     sat, sat_next, sat_inc, overflow_next, valid_next;

    assign sig_edge   = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign start_rise = start & ~start_prev;
    assign stop_rise  = stop & ~stop_prev;
    assign busy       = (state == COUNTING);

    // Edge detectors run every cycle regardless of enable, so strobes seen while disabled are lost.
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values, like real hardware.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync_q     <= '0;
            sync_prev  <= 1'b0;
            start_prev <= 1'b0;
            stop_prev  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], signal_in};
            sync_prev  <= sync_q[SYNC_STAGES-1];
            start_prev <= start;
            stop_prev  <= stop;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            counter      <= '0;
            sat          <= 1'b0;
            frequency    <= '0;
            overflow     <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_next;
            counter      <= counter_next;
            sat          <= sat_next;
            frequency    <= frequency_next;
            overflow     <= overflow_next;
            result_valid <= valid_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next     = state;
        counter_next   = counter;
        sat_next       = sat;
        frequency_next = frequency;
        overflow_next  = overflow;
        valid_next     = 1'b0;
        cnt_inc        = counter;
        sat_inc        = sat;

        if (sig_edge) begin
            if (&counter) sat_inc = 1'b1;
            else          cnt_inc = counter + COUNTER_WIDTH'(1);
        end

        if (enable) begin
            unique case (state)
                IDLE: begin
                    if (start_rise) begin
                        state_next   = COUNTING;
                        counter_next = '0;
                        sat_next     = 1'b0;
                    end
                end
                COUNTING: begin
                    counter_next = cnt_inc;
                    sat_next     = sat_inc;
                    if (stop_rise) begin
                        frequency_next = cnt_inc;
                        overflow_next  = sat_inc;
                        valid_next     = 1'b1;
                        state_next     = IDLE;
                    end
                    // A start rise (alone or with stop) reopens a fresh window; a coincident edge is dropped.
                    if (start_rise) begin
                        counter_next = '0;
                        sat_next     = 1'b0;
                        state_next   = COUNTING;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

`ifdef PERIOD_MEASURE_EN
    logic [PERIOD_WIDTH-1:0] period_cnt, period_cnt_next, pc_inc;
    logic [PERIOD_WIDTH-1:0] interval_q, interval_next, last_period_next;
    logic [1:0]              seen, seen_next;

    always_ff @(posedge clock) begin
        if (!reset) begin
            period_cnt  <= '0;
            interval_q  <= '0;
            seen        <= '0;
            last_period <= '0;
        end else begin
            period_cnt  <= period_cnt_next;
            interval_q  <= interval_next;
            seen        <= seen_next;
            last_period <= last_period_next;
        end
    end

    // interval_q holds the distance between the two most recent counted edges; seen saturates at 2.
    always_comb begin
        period_cnt_next  = period_cnt;
        interval_next    = interval_q;
        seen_next        = seen;
        last_period_next = last_period;
        pc_inc           = (&period_cnt) ? period_cnt : period_cnt + PERIOD_WIDTH'(1);

        if (enable) begin
            if (state == COUNTING) begin
                period_cnt_next = sig_edge ? '0 : pc_inc;
                if (sig_edge) begin
                    interval_next = pc_inc;
                    seen_next     = (seen == 2'd2) ? seen : seen + 2'd1;
                end
                if (stop_rise)
                    last_period_next = (seen_next == 2'd2) ? interval_next : '0;
            end
            if (start_rise) begin
                period_cnt_next = '0;
                seen_next       = '0;
            end
        end
    end
`endif

endmodule
